ddr4_bringup_sequencer: RTL and testbench

Sequences bring-up of the DDR4 external memory interface on the DE10-Pro and gates the compute core's reset on it. It waits for device init-done, pulses the EMIF local reset request, then waits for reset-done and calibration. It retries a bounded number of times on failure or timeout. It releases the core reset only after calibration succeeds, and exposes ready/error/status for LEDs.

---
 rtl/ddr4_bringup_sequencer.sv | 163 ++++++++++++++++
 tb/tb_ddr4_bringup_sequencer.sv | 310 +++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/ddr4_bringup_sequencer.sv
// DDR4 EMIF bring-up sequencer: pulses the EMIF local reset, waits for reset-done and
// calibration with bounded retries, and holds the compute core in reset until memory is usable.
module ddr4_bringup_sequencer #(
  parameter int unsigned SETTLE_CYCLES    = 1024,
  parameter int unsigned RESET_REQ_CYCLES = 16,
  parameter int unsigned CAL_TIMEOUT      = 50000000,
  parameter int unsigned MAX_RETRIES      = 3
) (
  input  logic       clk,
  input  logic       reset_n,
  input  logic       init_done_n,
  input  logic       user_reset_n,
  input  logic       local_reset_done,
  input  logic       cal_success,
  input  logic       cal_fail,
  output logic       local_reset_req,
  output logic       core_reset_n,
  output logic       mem_ready,
  output logic       mem_error,
  output logic [3:0] retry_count,
  output logic [2:0] state_dbg
);

  localparam int unsigned MaxA      = (SETTLE_CYCLES > RESET_REQ_CYCLES) ? SETTLE_CYCLES
                                                                          : RESET_REQ_CYCLES;
  localparam int unsigned MaxCycles = (MaxA > CAL_TIMEOUT) ? MaxA : CAL_TIMEOUT;
  localparam int unsigned CntW      = $clog2(MaxCycles) + 1;

  // Counter is loaded with N-1 so a state that leaves at zero lasts exactly N cycles.
  localparam logic [CntW-1:0] SettleLoad = CntW'(SETTLE_CYCLES - 1);
  localparam logic [CntW-1:0] ReqLoad    = CntW'(RESET_REQ_CYCLES - 1);
  localparam logic [CntW-1:0] CalLoad    = CntW'(CAL_TIMEOUT - 1);
  localparam logic [3:0]      RetryMax   = 4'(MAX_RETRIES);

  typedef enum logic [2:0] {
    StWaitInit    = 3'd0,
    StSettle      = 3'd1,
    StReqReset    = 3'd2,
    StWaitRstDone = 3'd3,
    StWaitCal     = 3'd4,
    StReady       = 3'd5,
    StFailed      = 3'd6
  } state_e;

  state_e          state_q;
  logic [CntW-1:0] cnt_q;
  logic [3:0]      retry_q;
  logic            req_q, ready_q, error_q;

  logic [1:0] init_sync_q, user_sync_q, done_sync_q, ok_sync_q, fail_sync_q;

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      init_sync_q <= 2'b11;
      user_sync_q <= 2'b11;
      done_sync_q <= 2'b00;
      ok_sync_q   <= 2'b00;
      fail_sync_q <= 2'b00;
    end else begin
      init_sync_q <= {init_sync_q[0], init_done_n};
      user_sync_q <= {user_sync_q[0], user_reset_n};
      done_sync_q <= {done_sync_q[0], local_reset_done};
      ok_sync_q   <= {ok_sync_q[0], cal_success};
      fail_sync_q <= {fail_sync_q[0], cal_fail};
    end
  end

  logic init_done, user_ok, rst_done, cal_ok, cal_bad, cnt_zero, fail_now;

  assign init_done = ~init_sync_q[1];
  assign user_ok   = user_sync_q[1];
  assign rst_done  = done_sync_q[1];
  assign cal_ok    = ok_sync_q[1];
  assign cal_bad   = fail_sync_q[1];
  assign cnt_zero  = (cnt_q == '0);

  // cal_fail wins over cal_success, so simultaneous flags count as a failure.
  always_comb begin
    fail_now = 1'b0;
    unique case (state_q)
      StWaitRstDone: fail_now = !rst_done && cnt_zero;
      StWaitCal:     fail_now = cal_bad || (!cal_ok && cnt_zero);
      StReady:       fail_now = cal_bad || !cal_ok;
      default:       fail_now = 1'b0;
    endcase
  end

  always_ff @(posedge clk or negedge reset_n) begin
    if (!reset_n) begin
      state_q <= StWaitInit;
      cnt_q   <= '0;
      retry_q <= '0;
      req_q   <= 1'b0;
      ready_q <= 1'b0;
      error_q <= 1'b0;
    end else begin
      req_q   <= (state_q == StReqReset);
      ready_q <= (state_q == StReady);
      error_q <= (state_q == StFailed);

      if (!user_ok) begin
        state_q <= StWaitInit;
        retry_q <= '0;
      end else if (fail_now) begin
        if (retry_q < RetryMax) begin
          retry_q <= retry_q + 4'd1;
          cnt_q   <= SettleLoad;
          state_q <= StSettle;
        end else begin
          state_q <= StFailed;
        end
      end else begin
        unique case (state_q)
          StWaitInit: begin
            if (init_done) begin
              cnt_q   <= SettleLoad;
              state_q <= StSettle;
            end
          end
          StSettle: begin
            if (cnt_zero) begin
              cnt_q   <= ReqLoad;
              state_q <= StReqReset;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StReqReset: begin
            if (cnt_zero) begin
              cnt_q   <= CalLoad;
              state_q <= StWaitRstDone;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StWaitRstDone: begin
            if (rst_done) begin
              cnt_q   <= CalLoad;
              state_q <= StWaitCal;
            end else begin
              cnt_q <= cnt_q - 1'b1;
            end
          end
          StWaitCal: begin
            if (cal_ok) state_q <= StReady;
            else        cnt_q   <= cnt_q - 1'b1;
          end
          StReady:  state_q <= StReady;
          StFailed: state_q <= StFailed;
          default:  state_q <= StWaitInit;
        endcase
      end
    end
  end

  assign local_reset_req = req_q;
  assign core_reset_n    = ready_q;
  assign mem_ready       = ready_q;
  assign mem_error       = error_q;
  assign retry_count     = retry_q;
  assign state_dbg       = state_q;

endmodule

// File: tb/tb_ddr4_bringup_sequencer.sv
// Bench for ddr4_bringup_sequencer: a reactive EMIF stub plays per-attempt outcomes from a
// scenario table and predicts pulse timing, retries and final status from cycle arithmetic.
module tb_ddr4_bringup_sequencer;

  localparam int Settle     = 4;
  localparam int ReqW       = 2;
  localparam int CalTimeout = 100;
  localparam int MaxRetries = 2;
  localparam int SyncLat    = 3;  // drive after edge t -> FSM acts at edge t+3

  localparam int OcOk      = 0;
  localparam int OcCalFail = 1;
  localparam int OcRstTo   = 2;
  localparam int OcCalTo   = 3;

  typedef struct {
    int oc0;
    int oc1;
    int oc2;
    int d1;
    int d2;
    int exp_pulses;
    int exp_retry;
    int exp_ready;
    int exp_error;
  } vec_t;

  logic       clk = 1'b0;
  logic       reset_n = 1'b1;
  logic       init_done_n = 1'b1;
  logic       user_reset_n = 1'b1;
  logic       local_reset_done = 1'b0;
  logic       cal_success = 1'b0;
  logic       cal_fail = 1'b0;
  logic       local_reset_req, core_reset_n, mem_ready, mem_error;
  logic [3:0] retry_count;
  logic [2:0] state_dbg;

  int total = 0;
  int bad = 0;
  int cyc = 0;

  ddr4_bringup_sequencer #(
    .SETTLE_CYCLES   (Settle),
    .RESET_REQ_CYCLES(ReqW),
    .CAL_TIMEOUT     (CalTimeout),
    .MAX_RETRIES     (MaxRetries)
  ) dut (
    .clk             (clk),
    .reset_n         (reset_n),
    .init_done_n     (init_done_n),
    .user_reset_n    (user_reset_n),
    .local_reset_done(local_reset_done),
    .cal_success     (cal_success),
    .cal_fail        (cal_fail),
    .local_reset_req (local_reset_req),
    .core_reset_n    (core_reset_n),
    .mem_ready       (mem_ready),
    .mem_error       (mem_error),
    .retry_count     (retry_count),
    .state_dbg       (state_dbg)
  );

  always #5 clk = ~clk;
  always @(posedge clk) cyc <= cyc + 1;

  initial begin
    #500000;
    $display("FAIL watchdog: simulation did not finish, total=%0d bad=%0d", total, bad);
    $fatal(1);
  end

  task automatic check(input string name, input int act, input int exp);
    total++;
    if (act != exp) begin
      bad++;
      $display("FAIL %s: got %0d expected %0d (cycle %0d)", name, act, exp, cyc);
    end
  endtask

  function automatic logic sig(input int sel);
    case (sel)
      0:       return local_reset_req;
      1:       return mem_ready;
      default: return mem_error;
    endcase
  endfunction

  task automatic wait_for(input int sel, input logic lvl, input int budget, output bit ok);
    ok = 1'b0;
    for (int i = 0; i < budget; i++) begin
      if (sig(sel) === lvl) begin
        ok = 1'b1;
        break;
      end
      @(posedge clk);
      #1;
    end
  endtask

  function automatic int get_oc(input vec_t v, input int a);
    return (a == 0) ? v.oc0 : (a == 1) ? v.oc1 : v.oc2;
  endfunction

  // Outcome of a bring-up: the first successful attempt wins, otherwise all attempts are used.
  function automatic vec_t model(input vec_t v);
    vec_t r;
    int first_ok;
    r = v;
    first_ok = -1;
    for (int i = 0; i <= MaxRetries; i++)
      if (first_ok < 0 && get_oc(v, i) == OcOk) first_ok = i;
    if (first_ok >= 0) begin
      r.exp_pulses = first_ok + 1;
      r.exp_retry  = first_ok;
      r.exp_ready  = 1;
      r.exp_error  = 0;
    end else begin
      r.exp_pulses = MaxRetries + 1;
      r.exp_retry  = MaxRetries;
      r.exp_ready  = 0;
      r.exp_error  = 1;
    end
    return r;
  endfunction

  task automatic user_restart();
    local_reset_done = 1'b0;
    cal_success = 1'b0;
    cal_fail = 1'b0;
    user_reset_n = 1'b0;
    repeat (4) @(posedge clk);
    #1;
    user_reset_n = 1'b1;
  endtask

  task automatic run_scen(input vec_t v);
    bit ok;
    bit got_ready;
    int pred_rise, t_rise, fall, t_act, fail_edge, pulses, oc;
    user_restart();
    pred_rise = cyc + SyncLat + Settle + 1;
    pulses = 0;
    got_ready = 1'b0;
    t_act = 0;
    fail_edge = 0;
    for (int a = 0; a <= MaxRetries && !got_ready; a++) begin
      oc = get_oc(v, a);
      wait_for(0, 1'b1, 400, ok);
      check("req_rise_seen", int'(ok), 1);
      if (!ok) return;
      cal_fail = 1'b0;
      pulses++;
      check("req_rise_cycle", cyc, pred_rise);
      check("retry_during_req", int'(retry_count), a);
      t_rise = cyc;
      wait_for(0, 1'b0, 20, ok);
      check("req_fall_seen", int'(ok), 1);
      if (!ok) return;
      check("req_width", cyc - t_rise, ReqW);
      fall = cyc;
      if (oc == OcRstTo) begin
        // wait state was entered one cycle before the visible fall of the request
        fail_edge = fall - 1 + CalTimeout;
      end else begin
        repeat (v.d1) @(posedge clk);
        #1;
        local_reset_done = 1'b1;
        t_act = cyc;
        repeat (v.d2) @(posedge clk);
        #1;
        local_reset_done = 1'b0;
        if (oc == OcCalTo) begin
          fail_edge = t_act + SyncLat + CalTimeout;
        end else begin
          t_act = cyc;
          if (oc == OcOk) begin
            cal_success = 1'b1;
            got_ready = 1'b1;
          end else begin
            cal_fail = 1'b1;
            fail_edge = t_act + SyncLat;
          end
        end
      end
      if (!got_ready) pred_rise = fail_edge + Settle + 1;
    end
    if (got_ready) begin
      wait_for(1, 1'b1, 20, ok);
      check("ready_seen", int'(ok), 1);
      check("ready_cycle", cyc, t_act + SyncLat + 1);
      check("core_reset_in_ready", int'(core_reset_n), 1);
    end else begin
      wait_for(2, 1'b1, 300, ok);
      check("error_seen", int'(ok), 1);
      check("error_cycle", cyc, fail_edge + 1);
      check("state_failed", int'(state_dbg), 6);
      check("core_reset_in_failed", int'(core_reset_n), 0);
    end
    check("pulses", pulses, v.exp_pulses);
    check("retry_final", int'(retry_count), v.exp_retry);
    check("mem_ready_final", int'(mem_ready), v.exp_ready);
    check("mem_error_final", int'(mem_error), v.exp_error);
  endtask

  vec_t vecs[11];

  initial begin
    bit ok;
    int t;
    vec_t rv;

    vecs[0] = '{OcOk, OcOk, OcOk, 10, 20, 1, 0, 1, 0};
    vecs[1] = '{OcCalFail, OcOk, OcOk, 10, 20, 2, 1, 1, 0};
    vecs[2] = '{OcCalFail, OcCalFail, OcCalFail, 5, 8, 3, 2, 0, 1};
    vecs[3] = '{OcRstTo, OcRstTo, OcRstTo, 5, 8, 3, 2, 0, 1};
    vecs[4] = '{OcCalTo, OcRstTo, OcOk, 7, 12, 3, 2, 1, 0};
    for (int i = 5; i < 11; i++) begin
      rv.oc0 = int'($urandom_range(0, 3));
      rv.oc1 = int'($urandom_range(0, 3));
      rv.oc2 = int'($urandom_range(0, 3));
      rv.d1  = int'($urandom_range(1, 30));
      rv.d2  = int'($urandom_range(4, 30));
      vecs[i] = model(rv);
    end

    // Reset values
    #1 reset_n = 1'b0;
    repeat (3) @(posedge clk);
    #1;
    check("rst_local_reset_req", int'(local_reset_req), 0);
    check("rst_core_reset_n", int'(core_reset_n), 0);
    check("rst_mem_ready", int'(mem_ready), 0);
    check("rst_mem_error", int'(mem_error), 0);
    check("rst_retry_count", int'(retry_count), 0);
    check("rst_state_dbg", int'(state_dbg), 0);
    reset_n = 1'b1;

    // Device not yet configured: stays in WAIT_INIT
    repeat (10) @(posedge clk);
    #1;
    check("hold_wait_init", int'(state_dbg), 0);
    check("hold_no_req", int'(local_reset_req), 0);
    init_done_n = 1'b0;

    for (int i = 0; i < 11; i++) run_scen(vecs[i]);

    // User reset out of FAILED
    run_scen(vecs[2]);
    cal_fail = 1'b0;
    user_reset_n = 1'b0;
    repeat (6) @(posedge clk);
    #1;
    check("user_rst_state", int'(state_dbg), 0);
    check("user_rst_retry", int'(retry_count), 0);
    check("user_rst_error", int'(mem_error), 0);
    user_reset_n = 1'b1;

    // Loss of calibration in READY, then simultaneous success/fail flags
    run_scen(vecs[0]);
    cal_success = 1'b0;
    t = cyc;
    repeat (SyncLat) @(posedge clk);
    #1;
    check("loss_ready_still_up", int'(mem_ready), 1);
    @(posedge clk);
    #1;
    check("loss_ready_drop", int'(mem_ready), 0);
    check("loss_core_reset_drop", int'(core_reset_n), 0);
    wait_for(0, 1'b1, 50, ok);
    check("loss_retry_req_seen", int'(ok), 1);
    check("loss_retry_req_cycle", cyc, t + SyncLat + Settle + 1);
    check("loss_retry_count", int'(retry_count), 1);
    wait_for(0, 1'b0, 20, ok);
    repeat (10) @(posedge clk);
    #1;
    local_reset_done = 1'b1;
    repeat (5) @(posedge clk);
    #1;
    local_reset_done = 1'b0;
    cal_success = 1'b1;
    cal_fail = 1'b1;
    t = cyc;
    wait_for(0, 1'b1, 50, ok);
    check("both_flags_req_seen", int'(ok), 1);
    check("both_flags_req_cycle", cyc, t + SyncLat + Settle + 1);
    check("both_flags_retry", int'(retry_count), 2);
    cal_success = 1'b0;
    cal_fail = 1'b0;

    // Asynchronous reset while REQ_RESET is driving the request
    check("async_req_before", int'(local_reset_req), 1);
    #3 reset_n = 1'b0;
    #1;
    check("async_req_dropped", int'(local_reset_req), 0);
    check("async_state_cleared", int'(state_dbg), 0);
    check("async_retry_cleared", int'(retry_count), 0);
    repeat (3) @(posedge clk);
    #1;
    reset_n = 1'b1;
    t = cyc;
    wait_for(0, 1'b1, 50, ok);
    check("after_async_req_seen", int'(ok), 1);
    check("after_async_req_cycle", cyc, t + SyncLat + Settle + 1);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
